// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and field positions for the two-byte-instruction CPU sequencer
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 4;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int R1_MSB = 11;
  localparam int R1_LSB = 8;
  localparam int B2_MSB = 7;
  localparam int B2_LSB = 0;
  localparam int RB_MSB = 7;
  localparam int RB_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 0;

  localparam logic [ADDR_W-1:0] PC_STEP = 8'd2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_LDI  = 4'b0001,
    OP_LDM  = 4'b0010,
    OP_STM  = 4'b0011,
    OP_ADD  = 4'b1000,
    OP_HALT = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - data-memory req/ack bus between the sequencer and memory
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cpu_decoder.sv
// rtl/cpu_decoder.sv - combinational decode of the latched instruction word
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [15:0]       ir_i,
  output opcode_e           op_o,
  output logic [REG_W-1:0]  r1_o,
  output logic [REG_W-1:0]  rb_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [DATA_W-1:0] b2_o,
  output logic              illegal_op_o
);

  always_comb begin
    op_o         = OP_NOP;
    illegal_op_o = 1'b0;
    case (ir_i[OP_MSB:OP_LSB])
      OP_NOP, OP_LDI, OP_LDM, OP_STM, OP_ADD, OP_HALT:
        op_o = opcode_e'(ir_i[OP_MSB:OP_LSB]);
      default:
        illegal_op_o = 1'b1;
    endcase

    r1_o = ir_i[R1_MSB:R1_LSB];
    rd_o = ir_i[RD_MSB:RD_LSB];
    b2_o = ir_i[B2_MSB:B2_LSB];
    // Port B only carries a real operand for ADD; park it on R0 otherwise.
    rb_o = (op_o == OP_ADD) ? ir_i[RB_MSB:RB_LSB] : '0;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/EXEC/MEM/HALT control unit owning PC, IR and the memory timeout
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [DATA_W-1:0]  opcode1,
  input  logic [DATA_W-1:0]  opcode2,
  output logic [REG_W-1:0]   rf_raddr_a,
  output logic [REG_W-1:0]   rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  output logic               rf_we,
  output logic [REG_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               halted,
  output logic               illegal,
  output logic               bus_error,
  cpu_sequencer_if.master    mem
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [15:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  opcode_e            op;
  logic [REG_W-1:0]   r1, rb, rd;
  logic [DATA_W-1:0]  b2;
  logic               illegal_op;

  cpu_decoder u_decoder (
    .ir_i         (ir_q),
    .op_o         (op),
    .r1_o         (r1),
    .rb_o         (rb),
    .rd_o         (rd),
    .b2_o         (b2),
    .illegal_op_o (illegal_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_address = pc_q;
  assign rf_raddr_a  = r1;
  assign rf_raddr_b  = rb;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    cnt_d         = '0;
    rf_we         = 1'b0;
    rf_waddr      = r1;
    rf_wdata      = b2;
    halted        = 1'b0;
    illegal       = 1'b0;
    bus_error     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = b2;
    mem.mem_wdata = rf_rdata_a;

    case (state_q)
      S_FETCH: begin
        ir_d    = {opcode1, opcode2};
        pc_d    = pc_q + PC_STEP;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        illegal = illegal_op;
        state_d = S_FETCH;
        case (op)
          OP_LDI:         rf_we = 1'b1;
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = rf_rdata_a + rf_rdata_b;
          end
          OP_LDM, OP_STM: state_d = S_MEM;
          OP_HALT:        state_d = S_HALT;
          default:        ;
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (op == OP_STM);
        // An ack arriving on the final allowed cycle still completes the access.
        if (mem.mem_ack) begin
          if (op == OP_LDM) begin
            rf_we    = 1'b1;
            rf_wdata = mem.mem_rdata;
          end
          state_d = S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with ROM, register-file and memory models
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_address, opcode1, opcode2;
  logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic       rf_we, halted, illegal, bus_error;

  always #5 clk = ~clk;

  cpu_sequencer_if mem_bus ();

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_address (rom_address),
    .opcode1     (opcode1),
    .opcode2     (opcode2),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .halted      (halted),
    .illegal     (illegal),
    .bus_error   (bus_error),
    .mem         (mem_bus)
  );

  logic [7:0] rom [256];
  logic [7:0] rf  [16];

  assign opcode1    = rom[rom_address];
  assign opcode2    = rom[rom_address + 8'd1];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

  // Memory model: ack latency (0 = never) and load data depend on the address.
  function automatic int ack_at(input logic [7:0] a);
    case (a)
      8'h82:   return 3;
      8'h73:   return 1;
      8'h90:   return 1;
      8'h20:   return 15;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] load_val(input logic [7:0] a);
    case (a)
      8'h73:   return 8'h5A;
      8'h20:   return 8'h3C;
      default: return 8'hEE;
    endcase
  endfunction

  int req_cnt = 0;
  always @(posedge clk)
    if (reset || !mem_bus.mem_req || mem_bus.mem_ack) req_cnt <= 0;
    else req_cnt <= req_cnt + 1;

  assign mem_bus.mem_ack   = mem_bus.mem_req && (ack_at(mem_bus.mem_addr) != 0) &&
                             (req_cnt == ack_at(mem_bus.mem_addr) - 1);
  assign mem_bus.mem_rdata = load_val(mem_bus.mem_addr);

  int cyc = 0;
  always @(posedge clk) if (reset) cyc <= 0; else cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } st_t;
  wr_t exp_wr[$];
  st_t exp_st[$];

  int n_bus_err = 0, bus_err_cyc = 0, n_illegal = 0, illegal_pc = -1;
  int stm82_cycles = 0, stm82_we = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rf_we) begin
        if (exp_wr.size() == 0) check_eq("rf_we_unexpected", 32'(rf_waddr), 'hFFFF);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check_eq("rf_we_cycle", cyc + 1, e.cyc);
          check_eq("rf_waddr", 32'(rf_waddr), 32'(e.addr));
          check_eq("rf_wdata", 32'(rf_wdata), 32'(e.data));
        end
      end
      if (mem_bus.mem_ack && mem_bus.mem_we) begin
        if (exp_st.size() == 0) check_eq("store_unexpected", 32'(mem_bus.mem_addr), 'hFFFF);
        else begin
          st_t s;
          s = exp_st.pop_front();
          check_eq("store_addr", 32'(mem_bus.mem_addr), 32'(s.addr));
          check_eq("store_data", 32'(mem_bus.mem_wdata), 32'(s.data));
        end
      end
      if (bus_error) begin
        n_bus_err++;
        bus_err_cyc = cyc + 1;
      end
      if (illegal) begin
        n_illegal++;
        illegal_pc = 32'(rom_address);
      end
      if (mem_bus.mem_req && mem_bus.mem_addr == 8'h82) begin
        stm82_cycles++;
        if (mem_bus.mem_we) stm82_we++;
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    {rom[8'h00], rom[8'h01]} = 16'h10FF;  // LDI r0,FF
    {rom[8'h02], rom[8'h03]} = 16'h1101;  // LDI r1,01
    {rom[8'h04], rom[8'h05]} = 16'h8013;  // ADD r0+r1->r3
    {rom[8'h06], rom[8'h07]} = 16'h3382;  // STM r3->82, ack on 3rd cycle
    {rom[8'h08], rom[8'h09]} = 16'h2073;  // LDM r0<-73, ack at once
    {rom[8'h0A], rom[8'h0B]} = 16'h2210;  // LDM r2<-10, never acked
    {rom[8'h0C], rom[8'h0D]} = 16'h15A5;  // LDI r5,A5
    {rom[8'h0E], rom[8'h0F]} = 16'h3590;  // STM r5->90
    {rom[8'h10], rom[8'h11]} = 16'h2420;  // LDM r4<-20, ack on the timeout cycle
    {rom[8'hFE], rom[8'hFF]} = 16'h5000;  // undefined opcode

    exp_wr.push_back('{2,  4'd0, 8'hFF});
    exp_wr.push_back('{4,  4'd1, 8'h01});
    exp_wr.push_back('{6,  4'd3, 8'h00});
    exp_wr.push_back('{14, 4'd0, 8'h5A});
    exp_wr.push_back('{33, 4'd5, 8'hA5});
    exp_wr.push_back('{53, 4'd4, 8'h3C});
    exp_st.push_back('{8'h82, 8'h00});
    exp_st.push_back('{8'h90, 8'hA5});

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rom_address", 32'(rom_address), 0);
    check_eq("rst_rf_we", 32'(rf_we), 0);
    check_eq("rst_mem_req", 32'(mem_bus.mem_req), 0);
    check_eq("rst_mem_we", 32'(mem_bus.mem_we), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_illegal", 32'(illegal), 0);
    check_eq("rst_bus_error", 32'(bus_error), 0);
    reset = 1'b0;

    while (cyc + 1 < 12) @(negedge clk);
    check_eq("pc_after_stm", 32'(rom_address), 'h08);

    while (cyc < 60) @(negedge clk);
    {rom[8'h00], rom[8'h01]} = 16'hF000;  // HALT waits at the wrapped address

    t = 0;
    while (!halted && t < 800) begin
      @(negedge clk);
      t++;
    end
    check_eq("halt_reached", 32'(halted), 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("halt_stays", 32'(halted), 1);
      check_eq("halt_pc_frozen", 32'(rom_address), 'h02);
    end
    check_eq("illegal_count", n_illegal, 1);
    check_eq("illegal_pc_wrapped", illegal_pc, 0);
    check_eq("bus_error_count", n_bus_err, 1);
    check_eq("bus_error_cycle", bus_err_cyc, 31);
    check_eq("stm_req_cycles", stm82_cycles, 3);
    check_eq("stm_we_cycles", stm82_we, 3);
    check_eq("rf_writes_pending", exp_wr.size(), 0);
    check_eq("stores_pending", exp_st.size(), 0);

    reset = 1'b1;
    {rom[8'h00], rom[8'h01]} = 16'h2040;  // LDM that is never acked
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("halt_reset_halted", 32'(halted), 0);
    check_eq("halt_reset_pc", 32'(rom_address), 0);

    repeat (3) @(negedge clk);
    check_eq("mid_mem_req", 32'(mem_bus.mem_req), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mem_reset_req", 32'(mem_bus.mem_req), 0);
    check_eq("mem_reset_pc", 32'(rom_address), 0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 8-bit two-byte-instruction CPU. It owns the program counter, drives the instruction ROM address, latches each `{opcode1, opcode2}` pair and sequences the register file, the 8-bit adder and the data-memory port. Data memory is reached through a req/ack handshake with a timeout. The block sits between the ROM and the register-file/memory datapath and replaces ad-hoc stepping on a separate PC clock: everything runs on `clk`.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles `mem_req` stays high without `mem_ack` before the access is aborted.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rom_address` out 8: current PC.
- `opcode1`, `opcode2` in 8 each: ROM bytes at `rom_address` and `rom_address+1`, combinational.
- `rf_raddr_a`, `rf_raddr_b` out 4 each: register-file read addresses.
- `rf_rdata_a`, `rf_rdata_b` in 8 each: register-file read data.
- `rf_we` out 1: register-file write strobe.
- `rf_waddr` out 4: register-file write address.
- `rf_wdata` out 8: register-file write data.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_addr` out 8: data-memory address.
- `mem_wdata` out 8: store data.
- `mem_rdata` in 8: load data, valid when `mem_ack` = 1.
- `mem_ack` in 1: one-cycle completion pulse.
- `halted` out 1: high in the HALT state.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `bus_error` out 1: one-cycle pulse on a memory timeout.

## Operation
- Instruction register `ir[15:0] = {opcode1, opcode2}`. Fields: `op = ir[15:12]`, `r1 = ir[11:8]`, `b2 = ir[7:0]`.
- Opcodes:
  - 0000 NOP.
  - 0001 LDI: `R[r1] = b2`.
  - 0010 LDM: `R[r1] = M[b2]`.
  - 0011 STM: `M[b2] = R[r1]`.
  - 1000 ADD: `R[ir[3:0]] = R[r1] + R[ir[7:4]]`. Result is 8-bit and wraps; the carry is discarded.
  - 1111 HALT.
  - Any other opcode: `illegal` pulses and the instruction executes as a NOP.
- State machine:
  - FETCH: `ir <= {opcode1, opcode2}`, `pc <= pc + 2` (8-bit wrap, 254 -> 0). Next state is EXEC.
  - EXEC, NOP/LDI/ADD/illegal: the write (if any) happens this cycle. Next state is FETCH.
  - EXEC, LDM/STM: next state is MEM.
  - EXEC, HALT: next state is HALT.
  - MEM: hold `mem_req` = 1 with `mem_addr = b2`.
    - STM: `mem_we = 1`, `mem_wdata = rf_rdata_a` with `rf_raddr_a = r1`.
    - On `mem_ack`: LDM asserts `rf_we` with `rf_wdata = mem_rdata`, `rf_waddr = r1` in the same cycle. Next state is FETCH.
    - Timeout counter reaches `MEM_TIMEOUT` with no ack: `bus_error` pulses, no register write, next state is FETCH.
  - HALT: `halted` = 1, no further fetch, PC frozen. Only `reset` exits.
- Outputs are decoded combinationally from state and `ir`. Strobes are 0 in any state where they are not named.
- Register-file read addresses:
  - ADD: `rf_raddr_a = r1`, `rf_raddr_b = ir[7:4]`.
  - Otherwise: `rf_raddr_a = r1`, `rf_raddr_b = 0`.
- `mem_ack` while `mem_req` = 0 is ignored.
- `mem_ack` on the same cycle the counter reaches `MEM_TIMEOUT`: the ack wins and no `bus_error` is raised.
- ADD with `rd` equal to a source register: operands are read before the write and the write lands at the edge.

## Timing
- Reset values: `pc` = 0, state FETCH, `ir` = 0, timeout counter = 0. `rf_we`, `mem_req`, `mem_we`, `halted`, `illegal`, `bus_error` = 0. `rom_address` = 0.
- Latency:
  - NOP, LDI, ADD, illegal: 2 cycles.
  - LDM, STM: 2 + N cycles, where N is the number of MEM cycles including the ack cycle (N ≥ 1).
  - Timeout path: 2 + `MEM_TIMEOUT` cycles.
- `rom_address` changes only on the edge that leaves FETCH.
- Reset during MEM: `mem_req` drops on the cycle after the reset edge and any pending ack is ignored.
- Reset in HALT: the next cycle is FETCH at address 0.

## Structure
- `cpu_pkg` holds:
  - the `opcode_e` enum (NOP, LDI, LDM, STM, ADD, HALT);
  - the `state_e` enum (FETCH, EXEC, MEM, HALT);
  - field-position constants and the `PC_STEP = 2` constant.
- One combinational sub-module, `cpu_decoder`: maps `ir` to `opcode_e`, the register addresses and `illegal_op`.
- Everything else lives in `cpu_sequencer`: the FSM, PC, `ir` and the timeout counter.

## Test plan
- Reset, then program: LDI r0,FF; LDI r1,01; ADD r0+r1->r3. Required: `rf_we` with `waddr` = 0 / `wdata` = FF, then 1 / 01, then 3 / 00 (wrap), on cycles 2, 4 and 6 after reset release.
- STM r3 -> 0x82 with `mem_ack` on the 3rd MEM cycle. Required: `mem_req` = 1, `mem_we` = 1, `mem_addr` = 82, `mem_wdata` = `R3` for exactly 3 cycles; next FETCH at PC + 2.
- LDM r0 <- 0x73 with ack after 1 cycle and `mem_rdata` = 5A. Required: `rf_we`, `rf_waddr` = 0, `rf_wdata` = 5A in the ack cycle.
- LDM with no ack. Required: `bus_error` pulses after 15 MEM cycles, no `rf_we`, fetch resumes.
- Opcode 0101 at PC = FE, then HALT at 00. Required: `illegal` pulses once, PC wraps to 00, `halted` = 1 and stays high; `reset` returns to FETCH with PC = 0.
- `reset` asserted mid-MEM. Required: `mem_req` = 0 on the next cycle, `rom_address` = 0.
